// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard control bus between pipeline and hazard unit (HAZARD_PERF_EN adds stall counters)
interface pipeline_hazard_ctrl_if #(
   parameter int STAGES = 5,
   parameter int REG_W  = 5
);
   logic              halt;
   logic              dread;
   logic              dwrite;
   logic              dhit;
   logic              ihit;
   logic              branch_flush;
   logic              ex_dread;
   logic [REG_W-1:0]  ex_rd;
   logic [REG_W-1:0]  id_rs1;
   logic [REG_W-1:0]  id_rs2;
   logic              ex_mult;
   logic [STAGES-3:0] csr_busy;
   logic [STAGES-2:0] en;
   logic [STAGES-2:0] flush;
   logic              mult_busy;
   logic              halted;
`ifdef HAZARD_PERF_EN
   logic [31:0]       stall_mem;
   logic [31:0]       stall_mult;
   logic [31:0]       stall_data;

   modport master (
      output halt, dread, dwrite, dhit, ihit, branch_flush, ex_dread,
             ex_rd, id_rs1, id_rs2, ex_mult, csr_busy,
      input  en, flush, mult_busy, halted, stall_mem, stall_mult, stall_data
   );

   modport slave (
      input  halt, dread, dwrite, dhit, ihit, branch_flush, ex_dread,
             ex_rd, id_rs1, id_rs2, ex_mult, csr_busy,
      output en, flush, mult_busy, halted, stall_mem, stall_mult, stall_data
   );
`else
   modport master (
      output halt, dread, dwrite, dhit, ihit, branch_flush, ex_dread,
             ex_rd, id_rs1, id_rs2, ex_mult, csr_busy,
      input  en, flush, mult_busy, halted
   );

   modport slave (
      input  halt, dread, dwrite, dhit, ihit, branch_flush, ex_dread,
             ex_rd, id_rs1, id_rs2, ex_mult, csr_busy,
      output en, flush, mult_busy, halted
   );
`endif
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - N-stage hazard unit: enables/flushes, multiplier occupancy, halt drain (HAZARD_PERF_EN adds stall counters)
module pipeline_hazard_ctrl #(
   parameter int STAGES  = 5,
   parameter int REG_W   = 5,
   parameter int MUL_LAT = 4
) (
   input logic                   CLK,
   input logic                   nRST,
   pipeline_hazard_ctrl_if.slave bus
);
   localparam int R     = STAGES - 1;
   localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam int DRN_W = $clog2(STAGES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);
   localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'(STAGES - 2);
   localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             mult_done, mult_done_nxt;
   logic [DRN_W-1:0] drain_cnt, drain_cnt_nxt;

   logic             mem_stall;
   logic             mult_stall;
   logic             load_use;
   logic             csr_hold;
   logic             reg1_stall;
   logic             reg2_adv;
   logic [R-1:0]     en_run;
   logic [R-1:0]     flush_run;

   assign mem_stall  = (bus.dread | bus.dwrite) & ~bus.dhit;
   assign mult_stall = bus.ex_mult & ~mult_done & (cnt < CNT_LAST);
   assign load_use   = bus.ex_dread & (bus.ex_rd != '0) &
                       ((bus.ex_rd == bus.id_rs1) | (bus.ex_rd == bus.id_rs2));
   assign csr_hold   = |bus.csr_busy;

   // Stall/flush priority network while the core is not halted; a drain
   // outranks branch and data hazards because nothing new may enter execute.
   always_comb begin
      en_run    = '1;
      flush_run = '0;
      if (mem_stall) begin
         for (int r = 0; r < R - 1; r++) begin
            en_run[r] = 1'b0;
         end
         flush_run[R-1] = 1'b1;
      end else if (mult_stall) begin
         en_run[1:0]  = 2'b00;
         flush_run[2] = 1'b1;
      end else if (state == DRAIN) begin
         en_run[0]    = 1'b0;
         flush_run[1] = 1'b1;
      end else if (bus.branch_flush) begin
         flush_run[1:0] = 2'b11;
      end else if (load_use | csr_hold) begin
         en_run[0]    = 1'b0;
         flush_run[1] = 1'b1;
      end else if (~bus.ihit) begin
         flush_run[0] = 1'b1;
      end
   end

   assign reg1_stall = ~en_run[1] | flush_run[1];
   assign reg2_adv   = en_run[2] & ~flush_run[2] & (state != HALTED);

   // Output stage: reset forces bubbles everywhere, HALTED freezes everything
   always_comb begin
      bus.en        = en_run;
      bus.flush     = flush_run;
      bus.mult_busy = mult_stall;
      bus.halted    = 1'b0;
      if (!nRST) begin
         bus.en        = '0;
         bus.flush     = '1;
         bus.mult_busy = 1'b0;
      end else if (state == HALTED) begin
         bus.en     = '0;
         bus.flush  = '0;
         bus.halted = 1'b1;
      end
   end

   // Next-state logic for the multiplier tracker and the halt-drain FSM
   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      cnt_nxt       = cnt;
      mult_done_nxt = mult_done;

      if (!bus.ex_mult) begin
         cnt_nxt       = '0;
         mult_done_nxt = 1'b0;
      end else if (!mult_done) begin
         if (cnt < CNT_LAST) begin
            cnt_nxt = cnt + 1'b1;
         end else begin
            // Result ready but execute frozen: remember it so the same
            // multiply is not restarted once the memory stall clears.
            cnt_nxt       = '0;
            mult_done_nxt = mem_stall;
         end
      end else if (reg2_adv) begin
         cnt_nxt       = '0;
         mult_done_nxt = 1'b0;
      end

      case (state)
         RUN: begin
            if (bus.halt & ~bus.branch_flush & ~reg1_stall) begin
               state_nxt     = DRAIN;
               drain_cnt_nxt = DRN_INIT;
            end
         end
         DRAIN: begin
            if (!mem_stall) begin
               drain_cnt_nxt = drain_cnt - 1'b1;
               if (drain_cnt <= DRN_ONE) begin
                  state_nxt = HALTED;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // State registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= RUN;
         drain_cnt <= '0;
         cnt       <= '0;
         mult_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
         cnt       <= cnt_nxt;
         mult_done <= mult_done_nxt;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_mem, perf_mult, perf_data;
   logic        data_win;

   assign data_win = ~mem_stall & ~mult_stall & (state == RUN) &
                     ~bus.branch_flush & (load_use | csr_hold);

   // Saturating per-cause stall counters, frozen once halted
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         perf_mem  <= '0;
         perf_mult <= '0;
         perf_data <= '0;
      end else if (state != HALTED) begin
         if (mem_stall && (perf_mem != '1)) begin
            perf_mem <= perf_mem + 1'b1;
         end
         if (!mem_stall && mult_stall && (perf_mult != '1)) begin
            perf_mult <= perf_mult + 1'b1;
         end
         if (data_win && (perf_data != '1)) begin
            perf_data <= perf_data + 1'b1;
         end
      end
   end

   assign bus.stall_mem  = perf_mem;
   assign bus.stall_mult = perf_mult;
   assign bus.stall_data = perf_data;
`endif
endmodule
